// File: rtl/hexplay_sched.sv
`default_nettype none
// ============================================================================
// Module   : hexplay_sched
// Purpose  : Shares one 8-digit multiplexed hex display among four clients.
//            Owns the digit scan, grants the display round-robin with a
//            minimum hold time, and latches the owner's 32-bit word once per
//            scan frame so a frame never mixes two words or two owners.
// Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
// Ports:
//   CLK100MHZ     in   1    system clock
//   CPU_RESETN    in   1    asynchronous active-low reset
//   req           in   4    level request per client
//   data_in       in   128  client words, client k at [32k+31:32k]
//   grant         out  4    one-hot owner, zero when idle
//   hexplay_an    out  3    digit select
//   hexplay_data  out  4    nibble for the selected digit
//   frame_tick    out  1    one-cycle pulse after each frame boundary
// Parameters:
//   SCAN_DIV      clock cycles per digit (>= 2)
//   HOLD_FRAMES   minimum frames held while others wait (>= 1)
// Optional feature macro:
//   HEXPLAY_OWNER_TAG_EN  digit 7 shows the owner index while owned
// ============================================================================
module hexplay_sched #(
  parameter int SCAN_DIV    = 250000,
  parameter int HOLD_FRAMES = 100
) (
  input  logic         CLK100MHZ,
  input  logic         CPU_RESETN,
  input  logic [3:0]   req,
  input  logic [127:0] data_in,
  output logic [3:0]   grant,
  output logic [2:0]   hexplay_an,
  output logic [3:0]   hexplay_data,
  output logic         frame_tick
);

  localparam int SCAN_W = $clog2(SCAN_DIV);
  localparam int HOLD_W = (HOLD_FRAMES > 1) ? $clog2(HOLD_FRAMES) : 1;
  localparam logic [SCAN_W-1:0] SCAN_LAST = SCAN_W'(SCAN_DIV - 1);
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(HOLD_FRAMES - 1);

  typedef enum logic [0:0] {ST_IDLE = 1'b0, ST_OWN = 1'b1} state_t;

  state_t              state, state_n;
  logic [SCAN_W-1:0]   scan_cnt;
  logic [31:0]         shadow, shadow_n;
  logic [HOLD_W-1:0]   hold_cnt, hold_n;
  logic [1:0]          last_owner, last_n;
  logic [3:0]          grant_n;
  logic                digit_tick;
  logic                boundary;
  logic [1:0]          pick_idx;
  logic [3:0]          others;
  logic                take_pick;

  assign digit_tick = (scan_cnt == SCAN_LAST);
  // The boundary is the digit tick that wraps the digit select 7 -> 0.
  assign boundary   = digit_tick && (hexplay_an == 3'd7);

  // Scan timing
  always_ff @(posedge CLK100MHZ or negedge CPU_RESETN) begin
    if (!CPU_RESETN) begin
      scan_cnt   <= '0;
      hexplay_an <= 3'd0;
      frame_tick <= 1'b0;
    end else begin
      frame_tick <= boundary;
      if (digit_tick) begin
        scan_cnt   <= '0;
        hexplay_an <= hexplay_an + 3'd1;
      end else begin
        scan_cnt   <= scan_cnt + SCAN_W'(1);
      end
    end
  end

  // Round-robin pick: scan from last_owner+1 upward. Iterating downward and
  // overwriting leaves the closest asserted request. While the owner still
  // requests and another client does too, the closest one is never the owner
  // because the owner sits last in the rotation.
  always_comb begin
    pick_idx = last_owner;
    for (int i = 4; i >= 1; i--) begin
      if (req[last_owner + i[1:0]]) pick_idx = last_owner + i[1:0];
    end
  end

  assign others = req & ~(4'b0001 << last_owner);

  // Arbitration state register
  always_ff @(posedge CLK100MHZ or negedge CPU_RESETN) begin
    if (!CPU_RESETN) begin
      state      <= ST_IDLE;
      grant      <= 4'b0000;
      shadow     <= 32'd0;
      hold_cnt   <= '0;
      last_owner <= 2'd3;
    end else begin
      state      <= state_n;
      grant      <= grant_n;
      shadow     <= shadow_n;
      hold_cnt   <= hold_n;
      last_owner <= last_n;
    end
  end

  // Arbitration next state; only acts at a frame boundary.
  always_comb begin
    state_n   = state;
    grant_n   = grant;
    shadow_n  = shadow;
    hold_n    = hold_cnt;
    last_n    = last_owner;
    take_pick = 1'b0;
    if (boundary) begin
      case (state)
        ST_IDLE: begin
          if (|req) take_pick = 1'b1;
          else      shadow_n  = 32'd0;
        end
        ST_OWN: begin
          if (!req[last_owner]) begin
            if (|others) begin
              take_pick = 1'b1;
            end else begin
              state_n  = ST_IDLE;
              grant_n  = 4'b0000;
              shadow_n = 32'd0;
            end
          end else if ((|others) && (hold_cnt == HOLD_LAST)) begin
            take_pick = 1'b1;
          end else begin
            shadow_n = data_in[32*last_owner +: 32];
            if (hold_cnt != HOLD_LAST) hold_n = hold_cnt + HOLD_W'(1);
          end
        end
        default: state_n = ST_IDLE;
      endcase
      if (take_pick) begin
        state_n  = ST_OWN;
        grant_n  = 4'b0001 << pick_idx;
        last_n   = pick_idx;
        shadow_n = data_in[32*pick_idx +: 32];
        hold_n   = '0;
      end
    end
  end

  // Display path: digit 0 carries the least significant nibble.
  always_comb begin
    hexplay_data = shadow[{hexplay_an, 2'b00} +: 4];
`ifdef HEXPLAY_OWNER_TAG_EN
    if ((state == ST_OWN) && (hexplay_an == 3'd7)) hexplay_data = {2'b00, last_owner};
`endif
  end

endmodule
`default_nettype wire

// File: tb/tb_hexplay_sched.sv
`default_nettype none
// ============================================================================
// Module   : tb_hexplay_sched
// Purpose  : Self-checking bench for hexplay_sched with a frame-level
//            reference model, directed scenarios and randomized traffic.
// Revision : 1.0 - initial release
// ============================================================================
module tb_hexplay_sched;
  localparam int SD    = 4;
  localparam int HF    = 2;
  localparam int FRAME = 8 * SD;
`ifdef HEXPLAY_OWNER_TAG_EN
  localparam bit TAG = 1'b1;
`else
  localparam bit TAG = 1'b0;
`endif

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic [3:0]   req = 4'b0000;
  logic [127:0] data_in = '0;
  logic [3:0]   grant;
  logic [2:0]   hexplay_an;
  logic [3:0]   hexplay_data;
  logic         frame_tick;

  int vectors = 0;
  int errors  = 0;

  hexplay_sched #(.SCAN_DIV(SD), .HOLD_FRAMES(HF)) dut (
    .CLK100MHZ   (clk),
    .CPU_RESETN  (rst_n),
    .req         (req),
    .data_in     (data_in),
    .grant       (grant),
    .hexplay_an  (hexplay_an),
    .hexplay_data(hexplay_data),
    .frame_tick  (frame_tick)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input int act, input int exp);
    vectors++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model (frame level) ----------------
  int          m_k = 0;       // clock edges since reset release
  int          m_owner = -1;  // -1 when nobody owns the display
  int          m_last = 3;
  int          m_frames = 0;  // whole frames completed by current owner
  logic [31:0] m_shadow = 32'd0;

  function automatic int rr(input logic [3:0] r, input int last);
    for (int i = 1; i <= 4; i++) begin
      if (r[(last + i) % 4]) return (last + i) % 4;
    end
    return -1;
  endfunction

  task automatic give(input int w);
    m_owner  = w;
    m_last   = w;
    m_frames = 0;
    m_shadow = data_in[32*w +: 32];
  endtask

  task automatic frame_end();
    logic [3:0] oth;
    oth = (m_owner < 0) ? req : (req & ~(4'b0001 << m_owner));
    if (m_owner < 0) begin
      if (req != 4'b0) give(rr(req, m_last));
      else             m_shadow = 32'd0;
    end else if (!req[m_owner]) begin
      if (oth != 4'b0) give(rr(oth, m_last));
      else begin m_owner = -1; m_shadow = 32'd0; end
    end else begin
      m_frames++;
      if (oth != 4'b0 && m_frames >= HF) give(rr(oth, m_last));
      else m_shadow = data_in[32*m_owner +: 32];
    end
  endtask

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_k = 0; m_owner = -1; m_last = 3; m_frames = 0; m_shadow = 32'd0;
    end else begin
      m_k++;
      if (m_k % FRAME == 0) frame_end();
    end
  end

  // ---------------- per-cycle comparison ----------------
  always @(negedge clk) begin : cmp
    int       e_an;
    int       e_data;
    e_an   = (m_k / SD) % 8;
    e_data = int'((m_shadow >> (4 * e_an)) & 32'hF);
    if (TAG && m_owner >= 0 && e_an == 7) e_data = m_owner;
    check("an", hexplay_an, e_an);
    check("frame_tick", frame_tick, (m_k > 0 && m_k % FRAME == 0) ? 1 : 0);
    check("grant", grant, (m_owner < 0) ? 0 : (1 << m_owner));
    check("data", hexplay_data, e_data);
  end

  // ---------------- helpers ----------------
  task automatic do_reset();
    @(negedge clk); #1;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    #1 rst_n = 1'b1;
  endtask

  task automatic wait_tick(output int n);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!frame_tick && n < 200);
    if (!frame_tick) check("tick_timeout", 0, 1);
  endtask

  logic [3:0] nibs [8];
  int         gseq [9];

  initial begin
    int n;
    nibs = '{4'hF, 4'hE, 4'hD, 4'hC, 4'hB, 4'hA, 4'h9, 4'h8};
    gseq = '{1, 1, 2, 2, 4, 4, 8, 8, 1};

    // Reset state and idle scan
    do_reset();
    @(negedge clk);
    check("rst_an", hexplay_an, 0);
    check("rst_grant", grant, 0);
    check("rst_data", hexplay_data, 0);
    check("rst_tick", frame_tick, 0);
    wait_tick(n);
    wait_tick(n);
    check("frame_period", n, 32);
    check("idle_grant", grant, 0);

    // Single grant, digit order
    req = 4'b0000;
    data_in = '0;
    data_in[64 +: 32] = 32'h89ABCDEF;
    do_reset();
    req = 4'b0100;
    wait_tick(n);
    check("single_grant", grant, 4'b0100);
    for (int d = 0; d < 8; d++) begin
      check("single_an", hexplay_an, d);
      check("single_nib", hexplay_data, (TAG && d == 7) ? 2 : nibs[d]);
      repeat (SD) @(negedge clk);
    end

    // Contention with everybody requesting
    data_in = {32'h44444444, 32'h33333333, 32'h22222222, 32'h11111111};
    req = 4'b1111;
    do_reset();
    for (int i = 0; i < 9; i++) begin
      wait_tick(n);
      check("rr_seq", grant, gseq[i]);
    end

    // Owner drop with a waiting client: direct switch, no idle frame
    req = 4'b1001;
    do_reset();
    wait_tick(n);
    check("drop_first", grant, 4'b0001);
    repeat (5) @(negedge clk);
    #1 req = 4'b1000;
    repeat (10) begin
      @(negedge clk);
      check("drop_frozen", grant, 4'b0001);
    end
    wait_tick(n);
    check("drop_switch", grant, 4'b1000);

    // No tearing on a mid-frame data change
    data_in = '0;
    data_in[31:0] = 32'h11111111;
    req = 4'b0001;
    do_reset();
    wait_tick(n);
    repeat (10) @(negedge clk);
    #1 data_in[31:0] = 32'h22222222;
    repeat (20) begin
      @(negedge clk);
      if (hexplay_an != 3'd7 || !TAG) check("tear_old", hexplay_data, 1);
    end
    wait_tick(n);
    check("tear_new", hexplay_data, 2);

    // Digit 7 with client 3 owning
    data_in = '0;
    data_in[96 +: 32] = 32'h5A5A5A5A;
    req = 4'b1000;
    do_reset();
    wait_tick(n);
    check("tag_grant", grant, 4'b1000);
    repeat (7 * SD) @(negedge clk);
    check("tag_an", hexplay_an, 7);
    check("tag_digit7", hexplay_data, TAG ? 3 : 5);

    // Randomized traffic with a mid-frame reset
    do_reset();
    for (int c = 0; c < 3000; c++) begin
      @(negedge clk); #1;
      if ($urandom_range(23, 0) == 0) req = 4'($urandom());
      if ($urandom_range(7, 0) == 0) data_in[32*$urandom_range(3, 0) +: 32] = $urandom();
      if (c == 1517) rst_n = 1'b0;
      if (c == 1519) rst_n = 1'b1;
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end
endmodule
`default_nettype wire

// File: doc/hexplay_sched.md
Name: hexplay_sched

Overview:
- Shares the board's single 8-digit multiplexed hex display (3-bit digit select, 4-bit nibble) among four requesters.
- Owns the digit-scan timing.
- Grants the display to one client at a time, round-robin, with a minimum hold time.
- Latches the owner's 32-bit word once per scan frame so no frame mixes two words or two owners.

Parameters:
- SCAN_DIV, 250000: clock cycles per digit; minimum 2.
- HOLD_FRAMES, 100: minimum whole frames an owner keeps the display while others are waiting; minimum 1.

Ports:
- CLK100MHZ  in  1  system clock.
- CPU_RESETN  in  1  reset; one clock, asynchronous, active-low.
- req  in  4  request per client; level-sensitive, held while display is wanted.
- data_in  in  128  client words; client k uses bits [32k+31:32k].
- grant  out  4  one-hot current owner; all-zero when idle.
- hexplay_an  out  3  digit select.
- hexplay_data  out  4  nibble for the selected digit.
- frame_tick  out  1  one-cycle pulse at each frame boundary.

Behaviour:
- Reset values: hexplay_an=0, grant=0, frame_tick=0, hexplay_data=0.
  - Internal state: scan_cnt=0, shadow=0, hold_cnt=0, last_owner=3 (so client 0 has first priority), state IDLE.
- Scan:
  - scan_cnt counts 0..SCAN_DIV-1 and wraps.
  - digit_tick = (scan_cnt==SCAN_DIV-1).
  - On digit_tick, hexplay_an increments mod 8 (7 wraps to 0).
  - frame_tick is registered. It is 1 in the cycle after the digit_tick that wraps hexplay_an from 7 to 0; 0 otherwise.
  - Arbitration happens on the same edge as that wrap (the "boundary").
- hexplay_data is combinational: shadow[4*an+3:4*an]. Digit 0 shows the least significant nibble.
- Round-robin pick: the first asserted req scanning from last_owner+1 upward, mod 4.
- State machine: IDLE and OWN; evaluated only at a boundary.
  - IDLE, no req: stay; shadow=0.
  - IDLE, any req: pick winner. grant=onehot(winner), last_owner=winner, shadow=winner's data_in, hold_cnt=0. Go to OWN.
  - OWN, req[owner]=0:
    - If another req, switch directly to the RR pick; load shadow; hold_cnt=0.
    - Otherwise grant=0, shadow=0, go to IDLE.
  - OWN, req[owner]=1, another req asserted, hold_cnt>=HOLD_FRAMES-1: switch to the RR pick; load shadow; hold_cnt=0.
  - OWN, otherwise: keep owner; shadow reloads from the owner's data_in; hold_cnt increments, saturating at HOLD_FRAMES-1.
- Between boundaries, grant and shadow are frozen. req and data_in changes mid-frame have no visible effect until the next boundary.
- Latency: a req asserted during frame F is granted at the end of F at the earliest; its data appears on digit 0 in the cycle of that boundary.
- Simultaneous events:
  - Owner drop and a new req at the same boundary: handled as a direct switch, no idle frame.
  - Several new reqs: strict RR order.
- Owner never self-preempts. With a sole requester, it holds indefinitely.
- Reset mid-frame: all state returns to reset values immediately. The next boundary is a full 8*SCAN_DIV cycles after release.
- grant is always zero or one-hot.

Optional Feature:
- HEXPLAY_OWNER_TAG_EN
  - Defined: when in OWN, digit 7 displays {2'b00, owner index} instead of shadow[31:28]. In IDLE, digit 7 displays 0 as usual.
  - Undefined: digit 7 shows shadow[31:28]; no tag logic is synthesized.

Test Plan:
- Reset check, SCAN_DIV=4: release reset with no req.
  - Required: hexplay_an steps 0..7 every 4 cycles; frame_tick pulses every 32 cycles; grant=0; hexplay_data=0 throughout.
- Single grant: req=4'b0100, data_in client 2 = 32'h89ABCDEF.
  - Required: at the first boundary grant=4'b0100; the following frame displays F,E,D,C,B,A,9,8 on an 0..7.
- Contention, HOLD_FRAMES=2: req=4'b1111 from reset.
  - Required: grant sequence 0001, 0010, 0100, 1000, 0001, each owner held exactly 2 frames.
- Drop with waiting client: owner 0 drops req mid-frame while req[3]=1.
  - Required: grant stays 0001 until the boundary, then 1000, with no IDLE frame.
- No tearing: change the owner's data_in from 32'h11111111 to 32'h22222222 mid-frame.
  - Required: all 8 digits show 1 for the rest of the frame; all show 2 from the next boundary.
- Tag feature: with HEXPLAY_OWNER_TAG_EN defined and client 3 owning, digit 7 shows 4'h3.
  - Required: with the macro undefined, digit 7 shows data bits [31:28].
